// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush controller for the 5-stage pipeline: load-use, taken branch, multi-cycle EX, memory freeze.
// Optional macro HAZARD_PERF_EN adds saturating stall/flush performance counters.
module pipe_hazard_ctrl #(
  parameter int MUL_LAT = 4,
  parameter int CNT_W   = 3
) (
  input  logic       clk_i,
  input  logic       rst_n,
  input  logic [4:0] id_rs_i,
  input  logic [4:0] id_rt_i,
  input  logic       id_uses_rt_i,
  input  logic       ex_memread_i,
  input  logic [4:0] ex_rt_i,
  input  logic       ex_mul_start_i,
  input  logic       branch_taken_i,
  input  logic       mem_stall_i,
  output logic       pc_write_o,
  output logic       ifid_write_o,
  output logic       ifid_flush_o,
  output logic       idex_write_o,
  output logic       idex_flush_o,
  output logic       exmem_write_o,
  output logic       exmem_flush_o,
  output logic       memwb_write_o,
  output logic       mul_busy_o
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0] stall_cnt_o,
  output logic [15:0] flush_cnt_o
`endif
);

  typedef enum logic {RUN, MUL_WAIT} state_t;

  localparam bit              MUL_EN     = (MUL_LAT >= 2);
  localparam int              CNT_INIT_I = MUL_EN ? (MUL_LAT - 2) : 0;
  localparam logic [CNT_W-1:0] CNT_INIT  = CNT_W'(CNT_INIT_I);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             load_use;
  logic             branch_act;

  assign load_use = ex_memread_i && (ex_rt_i != 5'd0) &&
                    ((ex_rt_i == id_rs_i) || (id_uses_rt_i && (ex_rt_i == id_rt_i)));

  assign mul_busy_o = (state_q == MUL_WAIT);

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    branch_act    = 1'b0;
    pc_write_o    = 1'b1;
    ifid_write_o  = 1'b1;
    ifid_flush_o  = 1'b0;
    idex_write_o  = 1'b1;
    idex_flush_o  = 1'b0;
    exmem_write_o = 1'b1;
    exmem_flush_o = 1'b0;
    memwb_write_o = 1'b1;
    if (mem_stall_i) begin
      pc_write_o    = 1'b0;
      ifid_write_o  = 1'b0;
      idex_write_o  = 1'b0;
      exmem_write_o = 1'b0;
      memwb_write_o = 1'b0;
    end else if (state_q == RUN) begin
      if (branch_taken_i) begin
        branch_act   = 1'b1;
        ifid_write_o = 1'b0;
        ifid_flush_o = 1'b1;
        idex_write_o = 1'b0;
        idex_flush_o = 1'b1;
      end else if (MUL_EN && ex_mul_start_i) begin
        // EX keeps the op; a bubble goes into MEM while MEM/WB keeps draining
        pc_write_o    = 1'b0;
        ifid_write_o  = 1'b0;
        idex_write_o  = 1'b0;
        exmem_write_o = 1'b0;
        exmem_flush_o = 1'b1;
        state_d       = MUL_WAIT;
        cnt_d         = CNT_INIT;
      end else if (load_use) begin
        pc_write_o   = 1'b0;
        ifid_write_o = 1'b0;
        idex_write_o = 1'b0;
        idex_flush_o = 1'b1;
      end
    end else begin
      if (cnt_q != '0) begin
        pc_write_o    = 1'b0;
        ifid_write_o  = 1'b0;
        idex_write_o  = 1'b0;
        exmem_write_o = 1'b0;
        exmem_flush_o = 1'b1;
        cnt_d         = cnt_q - 1'b1;
      end else begin
        state_d = RUN;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef HAZARD_PERF_EN
  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic [31:0] stall_cnt_q;
  logic [15:0] flush_cnt_q;

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (!pc_write_o && !mem_stall_i) stall_cnt_q <= sat_inc32(stall_cnt_q);
      if (branch_act)                  flush_cnt_q <= sat_inc16(flush_cnt_q);
    end
  end

  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;
`endif

endmodule
